// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by the transmit and receive blocks.
package i2s_pkg;

  // Default frame geometry: 32 bclk periods per half-frame, 24-bit samples.
  localparam int I2S_SLOT_WIDTH  = 32;
  localparam int I2S_DATA_WIDTH  = 24;
  localparam int I2S_FIFO_DEPTH  = 4;
  localparam int I2S_SYNC_STAGES = 2;

  // lrclk level identifying each channel.
  localparam logic I2S_CH_LEFT  = 1'b0;
  localparam logic I2S_CH_RIGHT = 1'b1;

  // Saturating increment of a slot bit counter.
  function automatic logic [7:0] i2s_sat_inc(input logic [7:0] cnt, input logic [7:0] max_cnt);
    return (cnt >= max_cnt) ? max_cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/i2s_rx_stream_sync_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty flags.
// A write into a full FIFO is accepted when a read happens in the same cycle.
module sync_fifo #(
  parameter int width = 25,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  input  logic             rd_en,
  output logic [width-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_ok;
  logic             rd_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(depth));
  assign rd_ok   = rd_en & ~empty;
  assign wr_ok   = wr_en & (~full | rd_ok);
  assign rd_data = mem_q[rd_ptr_q];

  // Storage array write port.
  // NOTE: the data array has no reset; stale contents are never visible because
  //       readers only look at it while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Read/write pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/i2s_rx_stream.sv
// I2S receiver: oversamples bclk/lrclk/sdata on clk, deserializes each slot
// MSB-first after the one-bit I2S delay and streams {channel, sample} words
// out of a small FWFT FIFO with valid/ready handshaking.
module i2s_rx_stream
  import i2s_pkg::*;
#(
  parameter int data_width  = I2S_DATA_WIDTH,
  parameter int slot_width  = I2S_SLOT_WIDTH,
  parameter int fifo_depth  = I2S_FIFO_DEPTH,
  parameter int sync_stages = I2S_SYNC_STAGES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         bclk,
  input  logic                         lrclk,
  input  logic                         sdata,
  output logic signed [data_width-1:0] m_tdata,
  output logic                         m_tchannel,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         overflow,
  input  logic                         ovf_clear
);

  localparam int CNT_W = $clog2(slot_width);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(slot_width - 1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(data_width);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(data_width - 1);

  // Pin synchronizers: three parallel chains of equal depth keep the pins aligned.
  logic [sync_stages-1:0] bclk_sync_q;
  logic [sync_stages-1:0] lr_sync_q;
  logic [sync_stages-1:0] sd_sync_q;
  logic                   bclk_s;
  logic                   lr_s;
  logic                   sd_s;

  // Edge detection.
  logic bclk_prev_q;
  logic rise_q;

  // Deserializer state.
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  lr_prev_q, lr_prev_d;
  logic                  locked_q, locked_d;
  logic [data_width-1:0] shift_q, shift_d;
  logic                  push_q, push_d;
  logic [data_width:0]   word_q, word_d;

  // FIFO side.
  logic [data_width:0] fifo_rd_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                drop;
  logic                overflow_q;

  assign bclk_s = bclk_sync_q[sync_stages-1];
  assign lr_s   = lr_sync_q[sync_stages-1];
  assign sd_s   = sd_sync_q[sync_stages-1];

  // Shift the raw pins through the synchronizer chains.
  // NOTE: every clocked block uses non-blocking assignments so all flops sample
  //       pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[sync_stages-2:0], bclk};
      lr_sync_q   <= {lr_sync_q[sync_stages-2:0], lrclk};
      sd_sync_q   <= {sd_sync_q[sync_stages-2:0], sdata};
    end
  end

  // Register a one-cycle pulse for each synchronized bclk rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      bclk_prev_q <= bclk_s;
      rise_q      <= bclk_s & ~bclk_prev_q;
    end
  end

  // Next-state logic of the deserializer, evaluated only on a bclk rise.
  // NOTE: every variable gets its hold value first so no path leaves one
  //       unassigned, which would otherwise infer a latch.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    lr_prev_d = lr_prev_q;
    locked_d  = locked_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    word_d    = word_q;
    if (rise_q) begin
      if (lr_s != lr_prev_q) begin
        // Slot boundary: this bit is the I2S delay bit; any partial word is discarded.
        bit_cnt_d = '0;
        lr_prev_d = lr_s;
        locked_d  = 1'b1;
        shift_d   = '0;
      end else begin
        bit_cnt_d = (bit_cnt_q == CNT_MAX) ? CNT_MAX : bit_cnt_q + CNT_W'(1);
        // Counts 1..data_width carry sample bits; the rest of the slot is padding.
        if (bit_cnt_q < CNT_DATA) begin
          shift_d = {shift_q[data_width-2:0], sd_s};
          if (bit_cnt_q == CNT_LAST) begin
            push_d = locked_q;
            word_d = {lr_prev_q, shift_d};
          end
        end
      end
    end
  end

  // Deserializer registers; the completed word is handed to the FIFO one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= '0;
      lr_prev_q <= 1'b0;
      locked_q  <= 1'b0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      word_q    <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      lr_prev_q <= lr_prev_d;
      locked_q  <= locked_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
      word_q    <= word_d;
    end
  end

  assign pop  = m_tvalid & m_tready;
  assign drop = push_q & fifo_full & ~pop;

  sync_fifo #(
    .width (data_width + 1),
    .depth (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_q),
    .wr_data (word_q),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (ovf_clear) begin
      overflow_q <= 1'b0;
    end
  end

  // FWFT outputs; forced to zero while empty so reset and idle both read as 0.
  assign m_tvalid   = ~fifo_empty;
  assign m_tdata    = fifo_empty ? '0 : fifo_rd_data[data_width-1:0];
  assign m_tchannel = fifo_empty ? I2S_CH_LEFT : fifo_rd_data[data_width];
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_i2s_rx_stream.sv
// Directed bench for i2s_rx_stream: bit-level I2S master driving the pins,
// a negedge monitor collecting accepted words, immediate-assertion checks.
module tb_i2s_rx_stream;

  localparam int DW = 24;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 bclk;
  logic                 lrclk;
  logic                 sdata;
  logic                 m_tready;
  logic                 ovf_clear;
  logic signed [DW-1:0] m_tdata;
  logic                 m_tchannel;
  logic                 m_tvalid;
  logic                 overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW:0] got_q[$];

  always #5 clk = ~clk;

  i2s_rx_stream #(
    .data_width  (DW),
    .slot_width  (32),
    .fifo_depth  (4),
    .sync_stages (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .m_tdata    (m_tdata),
    .m_tchannel (m_tchannel),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .overflow   (overflow),
    .ovf_clear  (ovf_clear)
  );

  // Record every word the DUT hands over (valid & ready, popped on the next posedge).
  always @(negedge clk) begin
    if (!reset && m_tvalid && m_tready) got_q.push_back({m_tchannel, m_tdata});
  end

  // Hard time limit so the run always ends.
  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish (observed running, required finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait n posedges, then settle 2 time units past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One bclk period (10 clk low, 10 clk high). mode 1 measures latency to m_tvalid
  // from the rising edge; mode 2 pulses m_tready for exactly the FIFO write cycle.
  task automatic send_bit(input logic lr, input logic d, input int mode);
    int n;
    bclk = 1'b0; lrclk = lr; sdata = d;
    tick(10);
    bclk = 1'b1;
    if (mode == 1) begin
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (!m_tvalid && n < 20);
      check("latency_cycles", 32'(n), 32'd5);
      tick(5);
    end else if (mode == 2) begin
      tick(4);
      m_tready = 1'b1;
      tick(1);
      m_tready = 1'b0;
      tick(5);
    end else begin
      tick(10);
    end
  endtask

  // One slot: bit 0 is the delay bit, bits 1..DW carry data MSB-first, rest zero.
  task automatic send_slot(input logic lr, input logic [DW-1:0] data, input int nbits, input int mode);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      b = (i >= 1 && i <= DW) ? data[DW-i] : 1'b0;
      send_bit(lr, b, (i == DW) ? mode : 0);
    end
  endtask

  task automatic expect_word(input string tag, input logic ch, input logic [DW-1:0] d);
    logic [31:0] w;
    if (got_q.size() > 0) w = 32'(got_q.pop_front());
    else                  w = 32'hFFFF_FFFF;
    check(tag, w, {7'd0, ch, d});
  endtask

  initial begin
    reset = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    m_tready = 1'b1; ovf_clear = 1'b0;
    tick(3);
    check("rst_tvalid",   32'(m_tvalid),   32'd0);
    check("rst_tdata",    {8'd0, m_tdata}, 32'd0);
    check("rst_tchannel", 32'(m_tchannel), 32'd0);
    check("rst_overflow", 32'(overflow),   32'd0);
    reset = 1'b0;
    tick(3);

    // 1: full left slot before any lrclk transition is not locked -> suppressed.
    send_slot(1'b0, 24'h123456, 32, 0);
    check("unlocked_no_word", 32'(got_q.size()), 32'd0);
    send_slot(1'b1, 24'hABCDEF, 32, 0);
    send_slot(1'b0, 24'h123456, 32, 0);
    send_slot(1'b1, 24'hABCDEF, 32, 0);
    send_slot(1'b0, 24'h123456, 32, 0);
    check("bfm_count", 32'(got_q.size()), 32'd4);
    expect_word("bfm_w0", 1'b1, 24'hABCDEF);
    expect_word("bfm_w1", 1'b0, 24'h123456);
    expect_word("bfm_w2", 1'b1, 24'hABCDEF);
    expect_word("bfm_w3", 1'b0, 24'h123456);

    // 2: latency from LSB bclk rise to m_tvalid on an empty FIFO.
    send_slot(1'b1, 24'hC3A50F, 32, 1);
    expect_word("lat_word", 1'b1, 24'hC3A50F);

    // 3: backpressure for 6 slots with depth 4.
    m_tready = 1'b0;
    send_slot(1'b0, 24'h100001, 32, 0);
    send_slot(1'b1, 24'h100002, 32, 0);
    check("bp_hold_data_early", {8'd0, m_tdata}, 32'h0010_0001);
    send_slot(1'b0, 24'h100003, 32, 0);
    send_slot(1'b1, 24'h100004, 32, 0);
    check("bp_no_ovf_at_full", 32'(overflow), 32'd0);
    send_slot(1'b0, 24'h100005, 32, 0);
    send_slot(1'b1, 24'h100006, 32, 0);
    check("bp_tvalid",         32'(m_tvalid),   32'd1);
    check("bp_hold_data_late", {8'd0, m_tdata}, 32'h0010_0001);
    check("bp_hold_channel",   32'(m_tchannel), 32'd0);
    check("bp_overflow_set",   32'(overflow),   32'd1);
    check("bp_nothing_popped", 32'(got_q.size()), 32'd0);
    m_tready = 1'b1;
    tick(10);
    check("bp_count", 32'(got_q.size()), 32'd4);
    expect_word("bp_w0", 1'b0, 24'h100001);
    expect_word("bp_w1", 1'b1, 24'h100002);
    expect_word("bp_w2", 1'b0, 24'h100003);
    expect_word("bp_w3", 1'b1, 24'h100004);
    check("bp_overflow_sticky", 32'(overflow), 32'd1);
    ovf_clear = 1'b1;
    tick(1);
    ovf_clear = 1'b0;
    check("bp_overflow_cleared", 32'(overflow), 32'd0);

    // 4: short left slot (10 bits) is discarded; following right slot is intact.
    send_slot(1'b0, 24'hFFFFFF, 10, 0);
    send_slot(1'b1, 24'h800001, 32, 0);
    check("short_count", 32'(got_q.size()), 32'd1);
    expect_word("short_next", 1'b1, 24'h800001);

    // 5: FIFO full, push lands in the same cycle as a pop.
    m_tready = 1'b0;
    send_slot(1'b0, 24'h200000, 32, 0);
    send_slot(1'b1, 24'h200001, 32, 0);
    send_slot(1'b0, 24'h200002, 32, 0);
    send_slot(1'b1, 24'h200003, 32, 0);
    send_slot(1'b0, 24'h200004, 32, 2);
    check("fp_no_overflow", 32'(overflow),   32'd0);
    check("fp_head_after",  {8'd0, m_tdata}, 32'h0020_0001);
    m_tready = 1'b1;
    tick(10);
    check("fp_count", 32'(got_q.size()), 32'd5);
    expect_word("fp_w0", 1'b0, 24'h200000);
    expect_word("fp_w1", 1'b1, 24'h200001);
    expect_word("fp_w2", 1'b0, 24'h200002);
    expect_word("fp_w3", 1'b1, 24'h200003);
    expect_word("fp_w4", 1'b0, 24'h200004);

    // 6: reset in the middle of a left slot (bit_cnt 12) with a word waiting.
    m_tready = 1'b0;
    send_slot(1'b1, 24'h5A5A5A, 32, 0);
    check("mid_pre_tvalid", 32'(m_tvalid),   32'd1);
    check("mid_pre_tdata",  {8'd0, m_tdata}, 32'h005A_5A5A);
    send_slot(1'b0, 24'h3C3C3C, 13, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_tvalid",   32'(m_tvalid),   32'd0);
    check("mid_rst_tdata",    {8'd0, m_tdata}, 32'd0);
    check("mid_rst_tchannel", 32'(m_tchannel), 32'd0);
    tick(3);
    reset = 1'b0;
    m_tready = 1'b1;
    tick(3);
    send_slot(1'b0, 24'h3C3C3C, 32, 0);
    check("relock_no_word", 32'(got_q.size()), 32'd0);
    send_slot(1'b1, 24'hABCDEF, 32, 0);
    send_slot(1'b0, 24'h123456, 32, 0);
    check("relock_count", 32'(got_q.size()), 32'd2);
    expect_word("relock_w0", 1'b1, 24'hABCDEF);
    expect_word("relock_w1", 1'b0, 24'h123456);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
